// File: rtl/vpu_result_writer.sv
// Result writer: buffers accumulator rows from the core in a 2-entry FIFO and streams them,
// one saturated element per cycle, into the result memory starting at a latched base address.
module vpu_result_writer #(
    parameter int unsigned ROW_A      = 4,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic                          in_valid,
    input  logic [OUT_WIDTH*ROW_A-1:0]    in_data,
    output logic                          in_ready,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         addr_res,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [$clog2(ROW_A*ROW_A):0]  count_store,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned TOTAL  = ROW_A * ROW_A;
    localparam int unsigned CNT_W  = $clog2(TOTAL) + 1;
    localparam int unsigned ROWS_W = $clog2(ROW_A) + 1;
    localparam int unsigned IDX_W  = (ROW_A > 1) ? $clog2(ROW_A) : 1;
    localparam int unsigned ROW_W  = OUT_WIDTH * ROW_A;

    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX =
        {{(OUT_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN =
        {{(OUT_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ROW_W-1:0]        fifo_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;
    logic [ROWS_W-1:0]       rows_q;
    logic [IDX_W-1:0]        elem_q;

    logic                    push;
    logic                    pop;
    logic                    have_head;
    logic                    wr_en;
    logic                    last_elem;
    logic [ROW_W-1:0]        head_row;
    logic signed [OUT_WIDTH-1:0] head_elem;

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [OUT_WIDTH-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    assign busy     = (state_q == StRun);
    assign in_ready = (state_q == StRun) && (occ_q < 2'd2) && (rows_q < ROWS_W'(ROW_A));
    assign push     = in_valid && in_ready;

    // An incoming row into an empty FIFO is written from straight away so its first
    // element reaches the memory port the cycle after acceptance.
    always_comb begin
        head_row  = (occ_q == 2'd0) ? in_data : fifo_q[rd_ptr_q];
        have_head = (occ_q != 2'd0) || push;
        head_elem = head_row[elem_q*OUT_WIDTH +: OUT_WIDTH];
        last_elem = (elem_q == IDX_W'(ROW_A - 1));
        wr_en     = (state_q == StRun) && have_head && (count_store < CNT_W'(TOTAL));
        pop       = wr_en && last_elem;
    end

    // Row storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            rows_q      <= '0;
            elem_q      <= '0;
            mem_we      <= 1'b0;
            addr_res    <= '0;
            mem_wdata   <= '0;
            count_store <= '0;
            done        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRun;
                        base_q      <= base_addr;
                        wr_ptr_q    <= 1'b0;
                        rd_ptr_q    <= 1'b0;
                        occ_q       <= 2'd0;
                        rows_q      <= '0;
                        elem_q      <= '0;
                        count_store <= '0;
                    end
                end
                StRun: begin
                    if (push) begin
                        wr_ptr_q <= ~wr_ptr_q;
                        rows_q   <= rows_q + ROWS_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_q <= ~rd_ptr_q;
                    end
                    unique case ({push, pop})
                        2'b10:   occ_q <= occ_q + 2'd1;
                        2'b01:   occ_q <= occ_q - 2'd1;
                        default: occ_q <= occ_q;
                    endcase
                    if (wr_en) begin
                        mem_we      <= 1'b1;
                        addr_res    <= base_q + ADDR_WIDTH'(count_store);
                        mem_wdata   <= saturate(head_elem);
                        count_store <= count_store + CNT_W'(1);
                        elem_q      <= last_elem ? '0 : elem_q + IDX_W'(1);
                    end
                    // Leave only once the final write is on the memory port.
                    if (count_store == CNT_W'(TOTAL)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_result_writer.sv
// Directed bench for vpu_result_writer with ROW_A=4, OUT_WIDTH=32, DATA_WIDTH=16, ADDR_WIDTH=8.
module tb_vpu_result_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   base_addr;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         mem_we;
    logic [7:0]   addr_res;
    logic [15:0]  mem_wdata;
    logic [4:0]   count_store;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int nw = 0;
    int ndone = 0;
    int done_cyc = 0;
    logic [7:0]  wr_addr [256];
    logic [15:0] wr_data [256];
    int          wr_cyc  [256];

    vpu_result_writer #(
        .ROW_A(4),
        .OUT_WIDTH(32),
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .addr_res(addr_res),
        .mem_wdata(mem_wdata),
        .count_store(count_store),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            if (nw < 256) begin
                wr_addr[nw] = addr_res;
                wr_data[nw] = mem_wdata;
                wr_cyc[nw]  = cyc;
            end
            nw++;
        end
        if (done) begin
            done_cyc = cyc;
            ndone++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_row(input logic [31:0] e0, input logic [31:0] e1,
                                            input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic send_row(input logic [127:0] row, input string tag, output int acc);
        int t = 0;
        in_valid = 1'b1;
        in_data  = row;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int t = 0; t < 100 && ndone == d0; t++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 64'(ndone - d0), 64'd1);
    endtask

    task automatic do_start(input logic [7:0] base);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int acc;
        int acc0;
        logic [15:0] exp3 [16];

        // Reset held low while inputs toggle
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        for (int i = 0; i < 6; i++) begin
            start     = i[0];
            in_valid  = ~i[0];
            base_addr = 8'(i * 37);
            in_data   = {4{32'(i + 1)}};
            @(negedge clk);
            check($sformatf("t1_outs_%0d", i),
                  {31'b0, in_ready, mem_we, busy, done, count_store, addr_res, mem_wdata}, 64'd0);
        end
        check("t1_no_writes", 64'(nw), 64'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t1_idle_after_release", {61'b0, in_ready, busy, mem_we}, 64'd0);

        // Basic tile: base 0x10, values 1..16 back to back
        do_start(8'h10);
        check("t2_busy", 64'(busy), 64'd1);
        w0 = nw;
        d0 = ndone;
        acc0 = 0;
        for (int r = 0; r < 4; r++) begin
            send_row(mk_row(32'(4*r+1), 32'(4*r+2), 32'(4*r+3), 32'(4*r+4)), "t2", acc);
            if (r == 0) acc0 = acc;
        end
        wait_done(d0, "t2_done_seen");
        @(negedge clk);
        @(negedge clk);
        check("t2_nwrites", 64'(nw - w0), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_addr_%0d", i), 64'(wr_addr[w0+i]), 64'(8'h10 + i));
            check($sformatf("t2_data_%0d", i), 64'(wr_data[w0+i]), 64'(i + 1));
        end
        check("t2_first_write_latency", 64'(wr_cyc[w0]), 64'(acc0));
        check("t2_writes_consecutive", 64'(wr_cyc[w0+15] - wr_cyc[w0]), 64'd15);
        check("t2_done_timing", 64'(done_cyc), 64'(wr_cyc[w0+15] + 1));
        check("t2_single_done", 64'(ndone - d0), 64'd1);
        check("t2_count_store", 64'(count_store), 64'd16);
        check("t2_idle_flags", {61'b0, busy, done, mem_we}, 64'd0);

        // Rows offered in IDLE are refused and change nothing
        in_valid = 1'b1;
        in_data  = mk_row(32'h55, 32'h66, 32'h77, 32'h88);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t2_idle_ready_%0d", i), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check("t2_idle_nwrites", 64'(nw - w0), 64'd16);
        check("t2_idle_count_hold", 64'(count_store), 64'd16);

        // Saturation, address wrap, in_valid held high with backpressure
        exp3[0] = 16'h7FFF;
        exp3[1] = 16'h8000;
        exp3[2] = 16'hFFFE;
        exp3[3] = 16'h7FFF;
        for (int i = 4; i < 16; i++) exp3[i] = 16'(32'h100 + i);
        in_valid = 1'b1;
        in_data  = mk_row(32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFE, 32'h0000_7FFF);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 8'hFC;
        @(negedge clk);
        check("t3_idle_not_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        w0 = nw;
        d0 = ndone;
        send_row(mk_row(32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFE, 32'h0000_7FFF), "t3_r0", acc);
        send_row(mk_row(32'h104, 32'h105, 32'h106, 32'h107), "t3_r1", acc);
        in_valid = 1'b1;
        in_data  = mk_row(32'h108, 32'h109, 32'h10A, 32'h10B);
        @(negedge clk);
        check("t3_full_not_ready", 64'(in_ready), 64'd0);
        send_row(mk_row(32'h108, 32'h109, 32'h10A, 32'h10B), "t3_r2", acc);
        send_row(mk_row(32'h10C, 32'h10D, 32'h10E, 32'h10F), "t3_r3", acc);
        in_valid = 1'b1;
        in_data  = mk_row(32'h5555, 32'h5555, 32'h5555, 32'h5555);
        @(negedge clk);
        check("t3_row_limit_not_ready", 64'(in_ready), 64'd0);
        wait_done(d0, "t3_done_seen");
        @(negedge clk);
        check("t3_after_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        check("t3_nwrites", 64'(nw - w0), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_addr_%0d", i), 64'(wr_addr[w0+i]), 64'(8'(8'hFC + i)));
            check($sformatf("t3_data_%0d", i), 64'(wr_data[w0+i]), 64'(exp3[i]));
        end
        check("t3_single_done", 64'(ndone - d0), 64'd1);

        // Reset mid-tile after six writes, then a fresh tile at 0x40
        do_start(8'h20);
        w0 = nw;
        d0 = ndone;
        send_row(mk_row(32'h200, 32'h201, 32'h202, 32'h203), "t4_r0", acc);
        send_row(mk_row(32'h204, 32'h205, 32'h206, 32'h207), "t4_r1", acc);
        for (int t = 0; t < 50 && (nw - w0) < 6; t++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t4_reset_outs",
              {31'b0, in_ready, mem_we, busy, done, count_store, addr_res, mem_wdata}, 64'd0);
        repeat (3) @(negedge clk);
        check("t4_no_writes_after_reset", 64'(nw - w0), 64'd6);
        check("t4_no_done_after_reset", 64'(ndone - d0), 64'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_pre_addr_%0d", i), 64'(wr_addr[w0+i]), 64'(8'h20 + i));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_start(8'h40);
        w0 = nw;
        d0 = ndone;
        for (int r = 0; r < 4; r++) begin
            send_row(mk_row(32'(32'h1000 + 4*r), 32'(32'h1001 + 4*r),
                            32'(32'h1002 + 4*r), 32'(32'h1003 + 4*r)), "t4_new", acc);
        end
        wait_done(d0, "t4_done_seen");
        repeat (3) @(negedge clk);
        check("t4_nwrites", 64'(nw - w0), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_addr_%0d", i), 64'(wr_addr[w0+i]), 64'(8'h40 + i));
            check($sformatf("t4_data_%0d", i), 64'(wr_data[w0+i]), 64'(32'h1000 + i));
        end
        check("t4_single_done", 64'(ndone - d0), 64'd1);
        check("t4_count_store", 64'(count_store), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
